nn_dot_engine: RTL and testbench



---
 rtl/nn_acc_pkg.sv | 49 ++++
 rtl/nn_dot_engine_if.sv | 32 +++
 rtl/nn_lane_mult_tree.sv | 64 ++++++
 rtl/nn_dot_engine.sv | 140 ++++++++++++++
 tb/tb_nn_dot_engine.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_acc_pkg.sv
// Shared types and helpers for the NN accumulator/neuron datapaths.
// Holds the neuron FSM state enum, default Q-format constants and the
// saturating re-quantiser used by nn_dot_engine and later layers.
package nn_acc_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC   = 8;

  // Widest value the saturate helper handles; accumulators must fit in it.
  localparam int MAX_W = 64;

  // Edges spent in DRAIN after the last beat before the result is formed:
  // products and tree sum still in flight, then the accumulator update.
  localparam logic [1:0] PIPE_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [MAX_W-1:0] val;
  } sat_t;

  // Clip a signed value to the dw-bit two's-complement range.
  function automatic sat_t nn_saturate(input logic signed [MAX_W-1:0] val,
                                       input int dw);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sat_t res;
    hi = $signed((MAX_W'(1) << (dw - 1)) - MAX_W'(1));
    lo = ~hi;
    res.sat = 1'b0;
    res.val = val;
    if (val > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (val < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_dot_engine_if.sv
// Configuration, input-stream and output-stream signals of the neuron engine.
// master = the fabric side driving work in; slave = the engine.
interface nn_dot_engine_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) ();

  logic                    cfg_start;
  logic [LEN_W-1:0]        cfg_len;
  logic [DATA_W-1:0]       cfg_bias;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_act;
  logic [LANES*DATA_W-1:0] in_wgt;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_sat;

  modport master (
    output cfg_start, cfg_len, cfg_bias, in_valid, in_act, in_wgt, out_ready,
    input  busy, in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  cfg_start, cfg_len, cfg_bias, in_valid, in_act, in_wgt, out_ready,
    output busy, in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/nn_lane_mult_tree.sv
// Two-stage lane multiplier: stage 1 registers LANES signed products,
// stage 2 registers their sign-extended sum. A valid bit follows each beat.
module nn_lane_mult_tree #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int SUM_W  = 34
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    beat_valid,
  input  logic [LANES*DATA_W-1:0] act,
  input  logic [LANES*DATA_W-1:0] wgt,
  output logic                    sum_valid,
  output logic signed [SUM_W-1:0] sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic                     prod_valid;
  logic signed [SUM_W-1:0]  sum_d;

  // Full-precision signed product per lane.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_W'($signed(act[i*DATA_W +: DATA_W]))
                * PROD_W'($signed(wgt[i*DATA_W +: DATA_W]));
    end
  end

  // Stage 1: capture products of an accepted beat.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prod_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      prod_valid <= beat_valid;
      if (beat_valid) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // Adder tree over the registered products, sign-extended to SUM_W.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  // Stage 2: capture the lane sum.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      sum_valid <= prod_valid;
      if (prod_valid) sum <= sum_d;
    end
  end

endmodule

// File: rtl/nn_dot_engine.sv
// Fixed-point dot-product neuron: LANES act/weight pairs per beat, cfg_len
// beats accumulated, bias added, re-quantised to DATA_W with saturation.
// Optional macro NN_RELU_EN clamps negative results to zero after saturation.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start, busy low
// ST_RUN   | accepting beats until cfg_len have transferred
// ST_DRAIN | letting the multiply/sum/accumulate pipeline empty
// ST_OUT   | result presented until the consumer takes it
module nn_dot_engine
  import nn_acc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16
) (
  input logic clk_clk,
  input logic reset_reset_n,
  nn_dot_engine_if.slave bus
);

  localparam int SUM_W = 2 * DATA_W + ((LANES > 1) ? $clog2(LANES) : 0);

  state_t                    state;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          beat_cnt;
  logic signed [DATA_W-1:0]  bias_q;
  logic [1:0]                drain_cnt;
  logic signed [ACC_W-1:0]   acc;

  logic                      beat_fire;
  logic                      sum_valid;
  logic signed [SUM_W-1:0]   sum;

  logic signed [ACC_W-1:0]   q_bias;
  logic signed [ACC_W-1:0]   q_r;
  sat_t                      q_res;
  logic [DATA_W-1:0]         q_data;
  logic                      q_sat;
  logic                      unused_q_hi;

  // in_ready is registered, so no path from in_valid back to in_ready.
  assign beat_fire = bus.in_valid && bus.in_ready;

  nn_lane_mult_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_mult_tree (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .beat_valid    (beat_fire),
    .act           (bus.in_act),
    .wgt           (bus.in_wgt),
    .sum_valid     (sum_valid),
    .sum           (sum)
  );

  // Re-quantise accumulator + bias back to Q(FRAC) at DATA_W, floor rounding.
  always_comb begin
    q_bias = ACC_W'(bias_q) <<< FRAC;
    q_r    = (acc + q_bias) >>> FRAC;
    q_res  = nn_saturate(MAX_W'(q_r), DATA_W);
    q_data = q_res.val[DATA_W-1:0];
    q_sat  = q_res.sat;
`ifdef NN_RELU_EN
    if (q_data[DATA_W-1]) q_data = '0;
`endif
  end

  assign unused_q_hi = ^q_res.val[MAX_W-1:DATA_W];

  // Sequencing FSM with registered handshake outputs and the accumulator.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      beat_cnt      <= '0;
      bias_q        <= '0;
      drain_cnt     <= '0;
      acc           <= '0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      if (sum_valid) acc <= acc + ACC_W'(sum);
      case (state)
        ST_IDLE: begin
          if (bus.cfg_start) begin
            len_q    <= bus.cfg_len;
            bias_q   <= $signed(bus.cfg_bias);
            beat_cnt <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            if (bus.cfg_len == '0) begin
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt + LEN_W'(1) == len_q) begin
              bus.in_ready <= 1'b0;
              drain_cnt    <= PIPE_DRAIN;
              state        <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            bus.out_data  <= q_data;
            bus.out_sat   <= q_sat;
            bus.out_valid <= 1'b1;
            state         <= ST_OUT;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_dot_engine.sv
// Self-checking bench for nn_dot_engine (LANES=4, DATA_W=16, FRAC=8).
// The reference model sums lane products of the beats actually transferred
// with 64-bit integers, adds the bias, floors, clips and (optionally) ReLUs.
module tb_nn_dot_engine;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int ACC_W  = 40;
  localparam int LEN_W  = 16;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit          exp_armed = 1'b0;
  logic [15:0] exp_data  = '0;
  logic        exp_sat   = 1'b0;

  logic [15:0] fix_act, fix_wgt;
  int          data_mode = 0;   // 0 fixed, 1 full-range random, 2 small random

  nn_dot_engine_if #(.LANES(LANES), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  nn_dot_engine #(
    .LANES (LANES), .DATA_W (DATA_W), .FRAC (FRAC), .ACC_W (ACC_W), .LEN_W (LEN_W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected neuron output from the exact integer dot product.
  function automatic void model_out(input longint dot, input logic [15:0] bias,
                                    output logic [15:0] d, output logic s);
    longint r;
    r = (dot + longint'($signed(bias)) * (longint'(1) << FRAC)) >>> FRAC;
    s = 1'b0;
    if (r > 32767) begin
      r = 32767;  s = 1'b1;
    end else if (r < -32768) begin
      r = -32768; s = 1'b1;
    end
`ifdef NN_RELU_EN
    if (r < 0) r = 0;
`endif
    d = r[15:0];
  endfunction

  // Put one beat on the bus and return its exact dot product.
  task automatic drive_beat(input bit v, output longint psum);
    logic [15:0] a, w;
    logic [9:0]  sa, sw;
    psum = 0;
    for (int i = 0; i < LANES; i++) begin
      if (data_mode == 0) begin
        a = fix_act; w = fix_wgt;
      end else if (data_mode == 1) begin
        a = 16'($urandom); w = 16'($urandom);
      end else begin
        sa = 10'($urandom); sw = 10'($urandom);
        a = {{6{sa[9]}}, sa}; w = {{6{sw[9]}}, sw};
      end
      bus.in_act[i*16 +: 16] = a;
      bus.in_wgt[i*16 +: 16] = w;
      psum += longint'($signed(a)) * longint'($signed(w));
    end
    bus.in_valid = v;
  endtask

  // Checks the DUT result every cycle it is presented.
  always @(negedge clk_clk) begin
    if (reset_reset_n && bus.out_valid) begin
      check("out_valid_expected", exp_armed, 1);
      if (exp_armed) begin
        check("out_data", bus.out_data, exp_data);
        check("out_sat", bus.out_sat, exp_sat);
      end
      check("in_ready_low_in_out", bus.in_ready, 0);
      check("busy_in_out", bus.busy, 1);
    end
  end

  // vpat: 0 always valid, 1 alternating from 1, 2 random ~60% valid.
  // Latency convention: a thing "from t+k" after edge t is seen on the
  // negedge following edge t+k-1.
  task automatic run_neuron(input int len, input logic [15:0] bias, input int vpat,
                            input int hold, input bit poke,
                            output logic [15:0] got_d, output logic got_s,
                            output logic [15:0] mdl_d);
    longint dot, psum;
    int beats, vcnt, last_edge;
    bit seen, v;
    dot = 0; beats = 0; vcnt = 0; seen = 0; last_edge = 0;
    got_d = '0; got_s = 1'b0;
    @(negedge clk_clk);
    bus.cfg_start = 1'b1;
    bus.cfg_len   = LEN_W'(len);
    bus.cfg_bias  = bias;
    last_edge     = cyc + 1;
    @(negedge clk_clk);
    bus.cfg_start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("in_ready_after_start", bus.in_ready, (len != 0) ? 1 : 0);
    if (len == 0) begin
      model_out(0, bias, exp_data, exp_sat);
      exp_armed = 1'b1;
    end
    for (int n = 0; n < 300 && !seen; n++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
      end else begin
        case (vpat)
          0:       v = 1'b1;
          1:       v = (vcnt % 2) == 0;
          default: v = $urandom_range(99) < 60;
        endcase
        vcnt++;
        drive_beat(v, psum);
        if (v && bus.in_ready) begin
          beats++;
          if (beats <= len) dot += psum;
          if (beats == len) begin
            last_edge = cyc + 1;
            model_out(dot, bias, exp_data, exp_sat);
            exp_armed = 1'b1;
          end
        end
        @(negedge clk_clk);
      end
    end
    bus.in_valid = 1'b0;
    mdl_d = exp_data;
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      exp_armed = 1'b0;
      return;
    end
    check("out_latency", cyc - last_edge, (len == 0) ? 1 : 3);
    check("beats_accepted", beats, len);
    got_d = bus.out_data;
    got_s = bus.out_sat;
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 1) begin
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 16'd1;
      end
      check("out_valid_held", bus.out_valid, 1);
      @(negedge clk_clk);
      bus.cfg_start = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk_clk);
    bus.out_ready = 1'b0;
    exp_armed = 1'b0;
    check("out_valid_after_hs", bus.out_valid, 0);
    check("busy_after_hs", bus.busy, 0);
    check("in_ready_after_hs", bus.in_ready, 0);
  endtask

  logic [15:0] gd, md;
  logic        gs;
  int          k_beats;
  longint      dummy;

  initial begin
    bus.cfg_start = 1'b0; bus.cfg_len = '0; bus.cfg_bias = '0;
    bus.in_valid = 1'b0; bus.in_act = '0; bus.in_wgt = '0; bus.out_ready = 1'b0;
    fix_act = 16'h0100; fix_wgt = 16'h0200;
    repeat (3) @(negedge clk_clk);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    reset_reset_n = 1'b1;

    // Basic single beat.
    data_mode = 0; fix_act = 16'h0100; fix_wgt = 16'h0200;
    run_neuron(1, 16'h0080, 0, 0, 0, gd, gs, md);
    check("basic_model", md, 16'h0880);
    check("basic_data", gd, 16'h0880);
    check("basic_sat", gs, 0);

    // Three beats with alternating valid bubbles.
    fix_act = 16'h0100; fix_wgt = 16'h0100;
    run_neuron(3, 16'h0000, 1, 2, 0, gd, gs, md);
    check("bubble_model", md, 16'h0C00);
    check("bubble_data", gd, 16'h0C00);

    // Positive and negative rail saturation.
    fix_act = 16'h7F00; fix_wgt = 16'h7F00;
    run_neuron(64, 16'h0000, 0, 0, 0, gd, gs, md);
    check("satpos_data", gd, 16'h7FFF);
    check("satpos_sat", gs, 1);
    fix_act = 16'h7F00; fix_wgt = 16'h8100;
    run_neuron(64, 16'h0000, 0, 1, 0, gd, gs, md);
`ifdef NN_RELU_EN
    check("satneg_data", gd, 16'h0000);
`else
    check("satneg_data", gd, 16'h8000);
`endif
    check("satneg_sat", gs, 1);

    // Negative result, no clipping.
    fix_act = 16'h0100; fix_wgt = 16'hFE00;
    run_neuron(1, 16'h0000, 0, 0, 0, gd, gs, md);
`ifdef NN_RELU_EN
    check("neg_data", gd, 16'h0000);
`else
    check("neg_data", gd, 16'hF800);
`endif
    check("neg_sat", gs, 0);

    // Zero-length neuron with long backpressure and a start pulse while busy.
    run_neuron(0, 16'h0123, 0, 10, 1, gd, gs, md);
    check("len0_data", gd, 16'h0123);
    check("len0_sat", gs, 0);
    check("poke_ignored_busy", bus.busy, 0);

    // Reset after 2 of 5 beats.
    fix_act = 16'h0100; fix_wgt = 16'h0200;
    @(negedge clk_clk);
    bus.cfg_start = 1'b1; bus.cfg_len = 16'd5; bus.cfg_bias = 16'h0000;
    @(negedge clk_clk);
    bus.cfg_start = 1'b0;
    k_beats = 0;
    drive_beat(1'b1, dummy);
    for (int n = 0; n < 20 && k_beats < 2; n++) begin
      if (bus.in_ready) k_beats++;
      @(negedge clk_clk);
    end
    check("beats_before_reset", k_beats, 2);
    #2 reset_reset_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_sat", bus.out_sat, 0);
    bus.in_valid = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    run_neuron(1, 16'h0080, 0, 0, 0, gd, gs, md);
    check("post_reset_data", gd, 16'h0880);

    // Randomised neurons.
    for (int t = 0; t < 24; t++) begin
      data_mode = (t % 3 == 0) ? 1 : 2;
      run_neuron(($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 8)),
                 16'($urandom), 2, int'($urandom_range(0, 3)), 1'($urandom),
                 gd, gs, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
